// File: rtl/fp_wb_pkg.sv
// Shared types for the FP writeback sequencer: format codes, FSM states,
// queued entry layout and the destination-mask helper.
package fp_wb_pkg;

    localparam logic [4:0] FMT_S = 5'h10;
    localparam logic [4:0] FMT_D = 5'h11;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

    typedef struct packed {
        logic        is_dbl;
        logic [4:0]  dst;
        logic [63:0] data;
    } entry_t;

    // Registers an entry will write; the high word of a double lands on dst+1 (mod 32).
    function automatic logic [31:0] dest_mask(entry_t e);
        logic [31:0] m;
        logic [4:0]  hi;
        hi = e.dst + 5'd1;
        m  = 32'h1 << e.dst;
        if (e.is_dbl) m = m | (32'h1 << hi);
        return m;
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Circular buffer of writeback entries with a per-slot valid view so the
// top level can OR together the destinations of everything still queued.
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output entry_t [DEPTH-1:0]     ents_o,
    output logic [DEPTH-1:0]       vld_o
);
    localparam int AW = $clog2(DEPTH);

    entry_t [DEPTH-1:0] mem_q;
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q, cnt_d;
    logic [DEPTH-1:0]   vld_q, vld_d;

    always_comb begin
        vld_d = vld_q;
        if (pop_i)  vld_d[rd_q] = 1'b0;
        if (push_i) vld_d[wr_q] = 1'b1;
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    // Payload needs no reset; the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign ents_o  = mem_q;
    assign vld_o   = vld_q;

endmodule

// File: rtl/fp_writeback_sequencer.sv
// FP register-file write front end: queues single/double results and drains
// them as 32-bit write beats. Optional odd-double rejection: FP_WB_ALIGN_CHECK_EN.
module fp_writeback_sequencer
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_fmt,
    input  logic [4:0]  in_reg,
    input  logic [63:0] in_data,
    output logic        FPRegWrite,
    output logic [4:0]  FPWriteRegister,
    output logic [31:0] FPWriteData,
    output logic [31:0] pending,
    output logic        idle,
    output logic        align_err
);
    logic                   accept, fmt_ok, odd_dbl, push, pop;
    logic                   full, empty;
    logic [$clog2(DEPTH):0] count;
    entry_t                 head, push_ent, beat;
    entry_t [DEPTH-1:0]     ents;
    logic [DEPTH-1:0]       vld;

    state_t      state_q, state_d;
    entry_t      cur_q, cur_d;
    logic        wr_q, wr_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pend;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign fmt_ok   = (in_fmt == FMT_S) || (in_fmt == FMT_D);

`ifdef FP_WB_ALIGN_CHECK_EN
    logic align_err_q;
    assign odd_dbl = (in_fmt == FMT_D) && in_reg[0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     align_err_q <= 1'b0;
        else if (accept && odd_dbl)  align_err_q <= 1'b1;
    end
    assign align_err = align_err_q;
`else
    assign odd_dbl   = 1'b0;
    assign align_err = 1'b0;
`endif

    // Unknown formats and rejected doubles still complete the handshake.
    assign push     = accept && fmt_ok && !odd_dbl;
    assign push_ent = '{is_dbl: (in_fmt == FMT_D), dst: in_reg, data: in_data};

    fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .ents_o      (ents),
        .vld_o       (vld)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        if (state_q == S_LO && cur_q.is_dbl) begin
            state_d = S_HI;
            addr_d  = cur_q.dst + 5'd1;
            data_d  = cur_q.data[63:32];
        end else if (!empty) begin
            pop     = 1'b1;
            cur_d   = head;
            state_d = S_LO;
            addr_d  = head.dst;
            data_d  = head.data[31:0];
        end else begin
            state_d = S_IDLE;
        end
        // r0 beats keep their slot but never assert the strobe.
        wr_d = (state_d != S_IDLE) && (addr_d != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i]) pend = pend | dest_mask(ents[i]);
        beat = cur_q;
        if (state_q == S_HI) begin
            beat.is_dbl = 1'b0;
            beat.dst    = cur_q.dst + 5'd1;
        end
        if (state_q != S_IDLE) pend = pend | dest_mask(beat);
        pend[0] = 1'b0;
    end

    assign pending         = pend;
    assign idle            = (count == '0) && (state_q == S_IDLE);
    assign FPRegWrite      = wr_q;
    assign FPWriteRegister = addr_q;
    assign FPWriteData     = data_q;

endmodule

// File: tb/tb_fp_writeback_sequencer.sv
// Scoreboard bench for fp_writeback_sequencer: expected write beats are queued
// at acceptance and retired as the DUT strobes FPRegWrite.
module tb_fp_writeback_sequencer;
    import fp_wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_fmt, in_reg;
    logic [63:0] in_data;
    logic        FPRegWrite;
    logic [4:0]  FPWriteRegister;
    logic [31:0] FPWriteData;
    logic [31:0] pending;
    logic        idle, align_err;

    int          vec = 0, err = 0, stall_cnt = 0;
    logic [36:0] sb[$];
    logic        exp_align;

    always #5 clk = ~clk;

    fp_writeback_sequencer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_fmt          (in_fmt),
        .in_reg          (in_reg),
        .in_data         (in_data),
        .FPRegWrite      (FPRegWrite),
        .FPWriteRegister (FPWriteRegister),
        .FPWriteData     (FPWriteData),
        .pending         (pending),
        .idle            (idle),
        .align_err       (align_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which beats with an asserted strobe a request produces.
    function automatic void model(input logic [4:0] f, input logic [4:0] r, input logic [63:0] d);
        logic [4:0] r1;
        r1 = r + 5'd1;
        if (f == FMT_S) begin
            if (r != 5'd0) sb.push_back({r, d[31:0]});
        end else if (f == FMT_D) begin
`ifdef FP_WB_ALIGN_CHECK_EN
            if (r[0]) begin
                exp_align = 1'b1;
                return;
            end
`endif
            if (r != 5'd0)  sb.push_back({r, d[31:0]});
            if (r1 != 5'd0) sb.push_back({r1, d[63:32]});
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [4:0] f, input logic [4:0] r, input logic [63:0] d);
        int n = 0;
        in_valid = 1'b1; in_fmt = f; in_reg = r; in_data = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stall_cnt += n;
        if (!in_ready) begin
            chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model(f, r, d);
        @(negedge clk);
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_fmt = '0; in_reg = '0; in_data = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((!idle || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_idle", {63'b0, idle}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && FPRegWrite) begin
            if (sb.size() == 0) chk("beat_unexpected", sb.size(), 1);
            else                chk("beat", {27'b0, FPWriteRegister, FPWriteData}, {27'b0, sb.pop_front()});
        end
    end

    initial begin
        rst = 1'b1; exp_align = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        chk("rst_wr",    {63'b0, FPRegWrite}, 0);
        chk("rst_addr",  {59'b0, FPWriteRegister}, 0);
        chk("rst_data",  {32'b0, FPWriteData}, 0);
        chk("rst_pend",  {32'b0, pending}, 0);
        chk("rst_idle",  {63'b0, idle}, 1);
        chk("rst_ready", {63'b0, in_ready}, 1);
        chk("rst_align", {63'b0, align_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // single to r3, two-cycle latency
        send(FMT_S, 5'd3, 64'hDEADBEEF_3F800000); idle_in();
        chk("s_pend_q", {63'b0, pending[3]}, 1);
        chk("s_nobeat", {63'b0, FPRegWrite}, 0);
        @(negedge clk);
        chk("s_wr", {63'b0, FPRegWrite}, 1);
        chk("s_beat", {27'b0, FPWriteRegister, FPWriteData}, {27'b0, 5'd3, 32'h3F800000});
        chk("s_pend_beat", {63'b0, pending[3]}, 1);
        @(negedge clk);
        chk("s_pend_clr", {63'b0, pending[3]}, 0);
        chk("s_idle", {63'b0, idle}, 1);

        // double to r4: low then high on consecutive cycles
        send(FMT_D, 5'd4, 64'h400921FB_54442D18); idle_in();
        chk("d_pend", {62'b0, pending[5:4]}, 3);
        @(negedge clk);
        chk("d_lo", {26'b0, FPRegWrite, FPWriteRegister, FPWriteData}, {26'b0, 1'b1, 5'd4, 32'h54442D18});
        chk("d_pend_lo", {63'b0, pending[5]}, 1);
        @(negedge clk);
        chk("d_hi", {26'b0, FPRegWrite, FPWriteRegister, FPWriteData}, {26'b0, 1'b1, 5'd5, 32'h400921FB});
        @(negedge clk);
        chk("d_idle", {63'b0, idle}, 1);

        // single to r0 still occupies its beat cycle
        send(FMT_S, 5'd0, 64'h0000_0000_AAAA5555);
        send(FMT_S, 5'd5, 64'h0000_0000_11111111); idle_in();
        chk("r0_wr", {63'b0, FPRegWrite}, 0);
        chk("r0_busy", {63'b0, idle}, 0);
        chk("r0_pend0", {63'b0, pending[0]}, 0);
        @(negedge clk);
        chk("r0_next", {26'b0, FPRegWrite, FPWriteRegister, FPWriteData}, {26'b0, 1'b1, 5'd5, 32'h11111111});
        @(negedge clk);

        // double to r31: high beat wraps to r0 and is suppressed
        send(FMT_D, 5'd31, 64'hCAFEF00D_12345678); idle_in();
        chk("r31_pend", {32'b0, pending}, 64'h8000_0000);
        @(negedge clk);
        chk("r31_lo", {26'b0, FPRegWrite, FPWriteRegister, FPWriteData}, {26'b0, 1'b1, 5'd31, 32'h12345678});
        @(negedge clk);
        chk("r31_hi_wr", {63'b0, FPRegWrite}, 0);
        chk("r31_hi_busy", {63'b0, idle}, 0);
        @(negedge clk);
        chk("r31_idle", {63'b0, idle}, 1);

        // unknown format: accepted and dropped
        send(5'h14, 5'd9, 64'h1); idle_in();
        chk("f14_pend", {32'b0, pending}, 0);
        chk("f14_idle", {63'b0, idle}, 1);
        repeat (3) begin
            @(negedge clk);
            chk("f14_nobeat", {63'b0, FPRegWrite}, 0);
        end

        // odd double to r7
        send(FMT_D, 5'd7, 64'h77777777_88888888); idle_in();
        chk("align_now", {63'b0, align_err}, {63'b0, exp_align});
        wait_drain();
        chk("align_sticky", {63'b0, align_err}, {63'b0, exp_align});

        // back-pressure: doubles every cycle outrun the drain
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send(FMT_D, 5'(2 * i + 2), {$urandom, $urandom});
        idle_in();
        chk("bp_stall_seen", {63'b0, stall_cnt > 0}, 1);
        wait_drain();
        for (int i = 0; i < DEPTH + 2; i++) send(FMT_S, 5'(i + 10), {32'b0, $urandom});
        idle_in();
        wait_drain();

        // random mix
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [4:0] f;
            k = $urandom_range(0, 9);
            f = (k < 4) ? FMT_S : (k < 9) ? FMT_D : 5'h14;
            send(f, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) begin
                idle_in();
                @(negedge clk);
            end
        end
        idle_in();
        wait_drain();
        chk("align_final", {63'b0, align_err}, {63'b0, exp_align});

        // reset asserted during a double's high beat
        send(FMT_D, 5'd12, 64'h5A5A5A5A_A5A5A5A5); idle_in();
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("mid_hi_live", {58'b0, FPRegWrite, FPWriteRegister}, {58'b0, 1'b1, 5'd13});
        rst = 1'b1;
        #1;
        sb.delete();
        exp_align = 1'b0;
        chk("mrst_wr",   {63'b0, FPRegWrite}, 0);
        chk("mrst_addr", {59'b0, FPWriteRegister}, 0);
        chk("mrst_data", {32'b0, FPWriteData}, 0);
        chk("mrst_pend", {32'b0, pending}, 0);
        chk("mrst_idle", {63'b0, idle}, 1);
        chk("mrst_align", {63'b0, align_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_quiet", {62'b0, FPRegWrite, idle}, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
